// File: rtl/dbg_mem_arbiter_if.sv
// Bus bundle for dbg_mem_arbiter: the core load/store request port, the debug
// bridge request port, the shared data-memory port and the arbiter status.
//
// Handshake semantics (all sampled on the rising clock edge):
//   core_req/core_ack : core_req is a level held until core_ack is seen;
//                       core_ack is a one-cycle pulse and core_rdata is valid
//                       only while core_ack=1.
//   dbg_req/dbg_ack   : dbg_req is a level held until dbg_ack is seen; dbg_ack
//                       stays high (dbg_rdata/err stable) until dbg_req falls.
//   mem_req/mem_ready : mem_req and mem_* are registered and held constant
//                       until the memory answers with mem_ready=1 (mem_rdata
//                       valid in that same cycle) or the wait times out.
interface dbg_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          dbg_halt;
  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_ack;
  logic [DW-1:0] core_rdata;
  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;
  logic          err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    grant;
  logic [2:0]    arb_state;

  // Arbiter side
  modport master (
    input  dbg_halt, core_req, core_we, core_addr, core_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_ready, mem_rdata,
    output core_ack, core_rdata, dbg_ack, dbg_rdata, err,
    output mem_req, mem_we, mem_addr, mem_wdata, grant, arb_state
  );

  // Requesters / memory / observer side
  modport slave (
    output dbg_halt, core_req, core_we, core_addr, core_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_ready, mem_rdata,
    input  core_ack, core_rdata, dbg_ack, dbg_rdata, err,
    input  mem_req, mem_we, mem_addr, mem_wdata, grant, arb_state
  );
endinterface

// File: rtl/dbg_mem_arbiter.sv
// dbg_mem_arbiter: shares the single data-memory port between the core
// load/store unit and the debug bridge. One requester owns the port at a time;
// simultaneous requests alternate round-robin. A granted access that gets no
// mem_ready within MAX_WAIT cycles is aborted and reported with err=1.
module dbg_mem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 16
) (
  input logic               CLK,
  input logic               RST,
  dbg_mem_arbiter_if.master bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ACC_CORE = 3'd1;
  localparam logic [2:0] S_ACC_DBG  = 3'd2;
  localparam logic [2:0] S_RSP_CORE = 3'd3;
  localparam logic [2:0] S_RSP_DBG  = 3'd4;

  // Counter is sized to hold MAX_WAIT itself so it never wraps.
  localparam int              CW        = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0]   WAIT_LAST = CW'(MAX_WAIT - 1);

  logic [2:0]    state;
  logic [CW-1:0] wait_cnt;
  logic          last_grant;     // 1 = debug was served last, 0 = core
  logic          core_ack_q;
  logic [DW-1:0] core_rdata_q;
  logic          dbg_ack_q;
  logic [DW-1:0] dbg_rdata_q;
  logic          err_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [1:0]    grant_q;

  logic          core_elig;
  logic          dbg_elig;
  logic          pick_core;
  logic          acc_done;
  logic [DW-1:0] acc_rdata;

  // Arbitration choice and access-completion decode
  always_comb begin
    core_elig = bus.core_req & ~bus.dbg_halt;
    dbg_elig  = bus.dbg_req;
    // Core wins when alone, or when both ask and debug was served last.
    pick_core = core_elig & (~dbg_elig | last_grant);
    // Finish on mem_ready, or abort on the last permitted wait cycle.
    acc_done  = bus.mem_ready | (wait_cnt == WAIT_LAST);
    // Writes and aborted accesses return zero; reads pass data untouched.
    acc_rdata = (bus.mem_ready & ~mem_we_q) ? bus.mem_rdata : '0;
  end

  // Arbiter FSM with registered memory-side and response-side outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      last_grant   <= 1'b1;
      core_ack_q   <= 1'b0;
      core_rdata_q <= '0;
      dbg_ack_q    <= 1'b0;
      dbg_rdata_q  <= '0;
      err_q        <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      grant_q      <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (core_elig || dbg_elig) begin
            mem_req_q <= 1'b1;
            wait_cnt  <= '0;
            err_q     <= 1'b0;
            if (pick_core) begin
              mem_we_q    <= bus.core_we;
              mem_addr_q  <= bus.core_addr;
              mem_wdata_q <= bus.core_wdata;
              grant_q     <= 2'b01;
              state       <= S_ACC_CORE;
            end else begin
              mem_we_q    <= bus.dbg_we;
              mem_addr_q  <= bus.dbg_addr;
              mem_wdata_q <= bus.dbg_wdata;
              grant_q     <= 2'b10;
              state       <= S_ACC_DBG;
            end
          end
        end

        S_ACC_CORE, S_ACC_DBG: begin
          // dbg_halt is deliberately ignored here: an issued access completes.
          if (!bus.mem_ready) begin
            wait_cnt <= wait_cnt + CW'(1);
          end
          if (acc_done) begin
            mem_req_q <= 1'b0;
            grant_q   <= 2'b00;
            err_q     <= ~bus.mem_ready;
            if (state == S_ACC_CORE) begin
              core_ack_q   <= 1'b1;
              core_rdata_q <= acc_rdata;
              state        <= S_RSP_CORE;
            end else begin
              dbg_ack_q   <= 1'b1;
              dbg_rdata_q <= acc_rdata;
              state       <= S_RSP_DBG;
            end
          end
        end

        S_RSP_CORE: begin
          // core_req is not looked at in the ack cycle, so no double issue.
          core_ack_q <= 1'b0;
          err_q      <= 1'b0;
          last_grant <= 1'b0;
          state      <= S_IDLE;
        end

        S_RSP_DBG: begin
          // The bridge is slow: keep the answer up until it drops its request.
          if (!bus.dbg_req) begin
            dbg_ack_q  <= 1'b0;
            err_q      <= 1'b0;
            last_grant <= 1'b1;
            state      <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.core_ack   = core_ack_q;
  assign bus.core_rdata = core_rdata_q;
  assign bus.dbg_ack    = dbg_ack_q;
  assign bus.dbg_rdata  = dbg_rdata_q;
  assign bus.err        = err_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.grant      = grant_q;
  assign bus.arb_state  = state;

endmodule
